// File: rtl/bichannel_responder_pkg.sv
// Shared definitions for the bidirectional channel responder: FSM state
// encoding, default parameter values and the turnaround counter width.
package bichannel_pkg;

  localparam int FLIT_W_DEF    = 32;
  localparam int DEPTH_DEF     = 4;
  localparam int GUARD_CYC_DEF = 2;
  localparam int HOLD_MAX_DEF  = 8;
  localparam int CNT_W         = 4;

  typedef enum logic [2:0] {
    ST_RX    = 3'd0,
    ST_REQ   = 3'd1,
    ST_TURN  = 3'd2,
    ST_TX    = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  // Terminal count for a phase lasting n cycles, counted from zero.
  function automatic logic [CNT_W-1:0] cnt_last(input int n);
    return CNT_W'(n - 1);
  endfunction

endpackage

// File: rtl/bichannel_responder_flit_fifo.sv
// Receive flit FIFO: registered storage with wrap-bit pointers, so the head
// is always a stored entry and a push becomes visible one cycle later.
module flit_fifo #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [FLIT_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [FLIT_W-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]     wr_q, wr_d;
  logic [PW-1:0]     rd_q, rd_d;
  logic [FLIT_W-1:0] mem_q [DEPTH];
  logic [FLIT_W-1:0] mem_d [DEPTH];
  logic              do_push_s;
  logic              do_pop_s;

  // Same index with differing wrap bits means every slot is occupied.
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty     = (wr_q == rd_q);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign head      = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    mem_d = mem_q;
    if (do_push_s) begin
      mem_d[wr_q[AW-1:0]] = push_data;
      wr_d                = wr_q + PW'(1);
    end else begin
      wr_d = wr_q;
    end
    if (do_pop_s) begin
      rd_d = rd_q + PW'(1);
    end else begin
      rd_d = rd_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      mem_q <= '{default: '0};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      mem_q <= mem_d;
    end
  end

endmodule

// File: rtl/bichannel_responder.sv
// Bidirectional channel end: negotiates ownership with the peer (peer wins
// ties), enforces turnaround guards and a hold limit, and buffers received flits.
module bichannel_responder
  import bichannel_pkg::*;
#(
  parameter int FLIT_W    = FLIT_W_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int GUARD_CYC = GUARD_CYC_DEF,
  parameter int HOLD_MAX  = HOLD_MAX_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              peer_output_req,
  input  logic              peer_release,
  input  logic              local_tx_req,
  input  logic              rx_valid,
  input  logic [FLIT_W-1:0] rx_flit,
  input  logic              out_ready,
  output logic              inout_select,
  output logic              output_req,
  output logic              tx_en,
  output logic              rx_ready,
  output logic              out_valid,
  output logic [FLIT_W-1:0] out_flit
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fifo_full_s;
  logic             fifo_empty_s;
  logic             push_s;
  logic             pop_s;

  // rst term keeps rx_ready low while reset is held even though state is RX.
  assign rx_ready  = (state_q == ST_RX) && !fifo_full_s && rst;
  assign out_valid = !fifo_empty_s;
  assign push_s    = rx_valid && rx_ready;
  assign pop_s     = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    inout_select = 1'b1;
    output_req   = 1'b0;
    tx_en        = 1'b0;
    case (state_q)
      ST_RX: begin
        cnt_d = '0;
        if (local_tx_req && !peer_output_req && !rx_valid) begin
          state_d = ST_REQ;
        end else begin
          state_d = ST_RX;
        end
      end
      ST_REQ: begin
        output_req = 1'b1;
        cnt_d      = '0;
        if (peer_output_req) begin
          state_d = ST_RX;
        end else if (peer_release) begin
          state_d = ST_TURN;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_TURN: begin
        inout_select = 1'b0;
        output_req   = 1'b1;
        if (cnt_q == cnt_last(GUARD_CYC)) begin
          state_d = ST_TX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_TX: begin
        inout_select = 1'b0;
        output_req   = 1'b1;
        tx_en        = 1'b1;
        if (!local_tx_req || (cnt_q == cnt_last(HOLD_MAX))) begin
          state_d = ST_DRAIN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DRAIN: begin
        inout_select = 1'b0;
        if (cnt_q == cnt_last(GUARD_CYC)) begin
          state_d = ST_RX;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_RX;
        cnt_d   = '0;
      end
    endcase
  end

  // Reset drops ownership at once; no drain guard is applied.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_RX;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  flit_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_s),
    .push_data (rx_flit),
    .pop       (pop_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .head      (out_flit)
  );

endmodule

// File: tb/tb_bichannel_responder.sv
// Self-checking bench: ownership phases tracked with countdown timers and the
// FIFO as a queue; outputs compared every negedge plus directed literal checks.
module tb_bichannel_responder;

  localparam int FW = 32;
  localparam int DP = 4;
  localparam int GC = 2;
  localparam int HM = 8;

  localparam int P_RX    = 0;
  localparam int P_REQ   = 1;
  localparam int P_TURN  = 2;
  localparam int P_TX    = 3;
  localparam int P_DRAIN = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          peer_output_req;
  logic          peer_release;
  logic          local_tx_req;
  logic          rx_valid;
  logic [FW-1:0] rx_flit;
  logic          out_ready;
  logic          inout_select;
  logic          output_req;
  logic          tx_en;
  logic          rx_ready;
  logic          out_valid;
  logic [FW-1:0] out_flit;

  always #5 clk = ~clk;

  bichannel_responder #(
    .FLIT_W    (FW),
    .DEPTH     (DP),
    .GUARD_CYC (GC),
    .HOLD_MAX  (HM)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .peer_output_req (peer_output_req),
    .peer_release    (peer_release),
    .local_tx_req    (local_tx_req),
    .rx_valid        (rx_valid),
    .rx_flit         (rx_flit),
    .out_ready       (out_ready),
    .inout_select    (inout_select),
    .output_req      (output_req),
    .tx_en           (tx_en),
    .rx_ready        (rx_ready),
    .out_valid       (out_valid),
    .out_flit        (out_flit)
  );

  int            n_cmp = 0;
  int            n_bad = 0;
  bit            chk_en = 1'b0;
  int            ph;
  int            left;
  int            budget;
  logic [FW-1:0] q[$];

  task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    ph     = P_RX;
    left   = 0;
    budget = 0;
    q.delete();
  endtask

  // Behavioural model: advance one clock using the inputs present at the edge.
  task automatic model_step();
    bit rdy, push, pop;
    if (rst !== 1'b1) begin
      m_reset();
      return;
    end
    rdy  = (ph == P_RX) && (q.size() < DP);
    push = rx_valid && rdy;
    pop  = out_ready && (q.size() > 0);
    if (pop) void'(q.pop_front());
    if (push) q.push_back(rx_flit);
    case (ph)
      P_RX: if (local_tx_req && !peer_output_req && !rx_valid) ph = P_REQ;
      P_REQ: begin
        if (peer_output_req) ph = P_RX;
        else if (peer_release) begin
          ph   = P_TURN;
          left = GC;
        end
      end
      P_TURN: begin
        left--;
        if (left == 0) begin
          ph     = P_TX;
          budget = HM;
        end
      end
      P_TX: begin
        budget--;
        if (!local_tx_req || budget == 0) begin
          ph   = P_DRAIN;
          left = GC;
        end
      end
      P_DRAIN: begin
        left--;
        if (left == 0) ph = P_RX;
      end
      default: ph = P_RX;
    endcase
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    peer_output_req = 1'b0;
    peer_release    = 1'b0;
    local_tx_req    = 1'b0;
    rx_valid        = 1'b0;
    rx_flit         = '0;
    out_ready       = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    m_reset();
    idle_inputs();
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  // Continuous comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("inout_select", {31'd0, inout_select}, {31'd0, (ph == P_RX || ph == P_REQ)});
      chk("output_req", {31'd0, output_req}, {31'd0, (ph == P_REQ || ph == P_TURN || ph == P_TX)});
      chk("tx_en", {31'd0, tx_en}, {31'd0, (ph == P_TX)});
      chk("rx_ready", {31'd0, rx_ready}, {31'd0, (ph == P_RX && q.size() < DP && rst === 1'b1)});
      chk("out_valid", {31'd0, out_valid}, {31'd0, (q.size() > 0)});
      if (q.size() > 0) chk("out_flit", out_flit, q[0]);
    end
  end

  initial begin
    int n_tx, n_drain, run, max_run;
    logic [FW-1:0] base;

    rst = 1'b0;
    idle_inputs();
    m_reset();
    #1;
    chk("reset_inout_select", {31'd0, inout_select}, 32'd1);
    chk("reset_output_req", {31'd0, output_req}, 32'd0);
    chk("reset_tx_en", {31'd0, tx_en}, 32'd0);
    chk("reset_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk_en = 1'b1;
    cyc();
    cyc();
    rst = 1'b1;

    // Request, peer releases on the third cycle, two turn cycles, then transmit.
    local_tx_req = 1'b1;
    cyc();
    chk("s1_req_output_req", {31'd0, output_req}, 32'd1);
    chk("s1_req_inout_select", {31'd0, inout_select}, 32'd1);
    cyc();
    peer_release = 1'b1;
    cyc();
    peer_release = 1'b0;
    chk("s1_turn1_inout_select", {31'd0, inout_select}, 32'd0);
    chk("s1_turn1_tx_en", {31'd0, tx_en}, 32'd0);
    cyc();
    chk("s1_turn2_tx_en", {31'd0, tx_en}, 32'd0);
    chk("s1_turn2_output_req", {31'd0, output_req}, 32'd1);
    cyc();
    chk("s1_tx_en", {31'd0, tx_en}, 32'd1);

    // Peer claim and release in the same REQ cycle: peer wins.
    do_reset();
    local_tx_req = 1'b1;
    cyc();
    chk("s2_in_req", {31'd0, output_req}, 32'd1);
    peer_output_req = 1'b1;
    peer_release    = 1'b1;
    cyc();
    peer_release = 1'b0;
    chk("s2_tie_output_req", {31'd0, output_req}, 32'd0);
    chk("s2_tie_inout_select", {31'd0, inout_select}, 32'd1);
    n_tx = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (tx_en === 1'b1) n_tx++;
    end
    chk("s2_no_tx_en", n_tx, 32'd0);
    peer_output_req = 1'b0;

    // Continuous transmit demand: hold limit then drain guard.
    do_reset();
    local_tx_req = 1'b1;
    peer_release = 1'b1;
    n_tx = 0; n_drain = 0; run = 0; max_run = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (i == 1) peer_release = 1'b0;
      if (tx_en === 1'b1) begin
        n_tx++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (inout_select === 1'b0 && output_req === 1'b0) n_drain++;
    end
    chk("s3_tx_cycles", n_tx, 32'd8);
    chk("s3_max_run", max_run, 32'd8);
    chk("s3_drain_cycles", n_drain, 32'd2);
    chk("s3_back_inout_select", {31'd0, inout_select}, 32'd1);
    local_tx_req = 1'b0;

    // Fill the FIFO, then pop at full with rx_valid still high.
    do_reset();
    base = 32'hA000_0000;
    rx_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      rx_flit = base + FW'(i);
      cyc();
    end
    chk("s4_full_rx_ready", {31'd0, rx_ready}, 32'd0);
    chk("s4_head0", out_flit, base + 32'd1);
    out_ready = 1'b1;
    rx_flit   = base + 32'd5;
    cyc();
    chk("s4_pop_only_head", out_flit, base + 32'd2);
    chk("s4_pop_only_rx_ready", {31'd0, rx_ready}, 32'd1);
    rx_flit = base + 32'd6;
    cyc();
    chk("s4_push_pop_head", out_flit, base + 32'd3);
    rx_valid = 1'b0;
    cyc();
    chk("s4_drain_head4", out_flit, base + 32'd4);
    cyc();
    chk("s4_drain_head6", out_flit, base + 32'd6);
    cyc();
    chk("s4_empty", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // Reset in the third transmit cycle with flits buffered.
    do_reset();
    rx_valid = 1'b1;
    rx_flit  = 32'h0000_0055;
    cyc();
    cyc();
    rx_valid     = 1'b0;
    local_tx_req = 1'b1;
    peer_release = 1'b1;
    cyc();
    cyc();
    peer_release = 1'b0;
    cyc();
    cyc();
    cyc();
    cyc();
    chk("s5_tx3_tx_en", {31'd0, tx_en}, 32'd1);
    rst = 1'b0;
    m_reset();
    #1;
    chk("s5_rst_output_req", {31'd0, output_req}, 32'd0);
    chk("s5_rst_tx_en", {31'd0, tx_en}, 32'd0);
    chk("s5_rst_inout_select", {31'd0, inout_select}, 32'd1);
    chk("s5_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("s5_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    cyc();
    rst = 1'b1;
    local_tx_req = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      peer_output_req = ($urandom_range(0, 9) == 0);
      peer_release    = ($urandom_range(0, 2) == 0);
      local_tx_req    = ($urandom_range(0, 3) != 0);
      rx_valid        = ($urandom_range(0, 1) == 1);
      rx_flit         = $urandom;
      out_ready       = ($urandom_range(0, 2) != 0);
      cyc();
    end

    idle_inputs();
    cyc();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bichannel_responder.md
BICHANNEL_RESPONDER -- requirements
Module: bichannel_responder

Interface
REQ-001 Parameter FLIT_W, 32, flit width in bits.
REQ-002 Parameter DEPTH, 4, receive FIFO entries (power of two, >=2).
REQ-003 Parameter GUARD_CYC, 2, bus-turnaround guard cycles, range 1..15.
REQ-004 Parameter HOLD_MAX, 8, maximum consecutive TX cycles per ownership, range 1..15.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 peer_output_req  input  1  peer end holds or claims the channel; peer wins all ties.
REQ-008 peer_release  input  1  peer has tristated its driver; valid only while output_req=1.
REQ-009 local_tx_req  input  1  local router has flits queued for this channel.
REQ-010 rx_valid  input  1  peer drives a valid flit on the channel.
REQ-011 rx_flit  input  FLIT_W  flit data from the channel.
REQ-012 out_ready  input  1  local input buffer accepts a flit.
REQ-013 inout_select  output  1  1 = channel is input (peer drives), 0 = output.
REQ-014 output_req  output  1  this end requests or holds channel ownership.
REQ-015 tx_en  output  1  local flit driver enabled this cycle.
REQ-016 rx_ready  output  1  FIFO accepts rx_flit this cycle.
REQ-017 out_valid  output  1  FIFO head valid.
REQ-018 out_flit  output  FLIT_W  FIFO head data.

Function
REQ-019 FSM states: RX, REQ, TURN, TX, DRAIN; encoding from shared package.
REQ-020 RX: inout_select=1, output_req=0, tx_en=0; go to REQ when local_tx_req=1, peer_output_req=0 and rx_valid=0.
REQ-021 REQ: inout_select=1, output_req=1; peer_output_req=1 returns to RX (takes priority over release); else peer_release=1 goes to TURN and clears cnt; else stay.
REQ-022 TURN: inout_select=0, output_req=1, tx_en=0; cnt increments; go to TX when cnt==GUARD_CYC-1, clearing cnt.
REQ-023 TX: inout_select=0, output_req=1, tx_en=1; cnt increments; go to DRAIN, clearing cnt, when local_tx_req=0 or cnt==HOLD_MAX-1.
REQ-024 DRAIN: inout_select=0, output_req=0, tx_en=0; cnt increments; go to RX when cnt==GUARD_CYC-1.
REQ-025 cnt is 4 bits, unsigned; it is cleared on every state transition and never wraps within legal parameter ranges.
REQ-026 Minimum ownership: local_tx_req held continuously gives exactly HOLD_MAX tx_en cycles, then GUARD_CYC DRAIN cycles before re-request is possible.
REQ-027 rx_ready = (state==RX) && !full && rst deasserted; it is not conditioned on same-cycle pop.
REQ-028 Push when rx_valid && rx_ready; pop when out_valid && out_ready; simultaneous push and pop keep the count unchanged.
REQ-029 Full: push blocked even if pop occurs the same cycle; empty: out_valid=0, so no pop occurs.
REQ-030 FIFO pointers are log2(DEPTH)+1 bits; wrap modulo 2*DEPTH; full/empty derive from MSB compare.
REQ-031 out_flit is registered FIFO storage, not a bypass; push-to-out_valid latency is 1 cycle.
REQ-032 FIFO contents are retained across direction changes; pops continue in any state.

Reset
REQ-033 rst low asynchronously forces state=RX, cnt=0, FIFO pointers=0.
REQ-034 During and after reset: inout_select=1, output_req=0, tx_en=0, rx_ready=0 while rst low, out_valid=0.
REQ-035 Reset mid-TX drops ownership immediately with no DRAIN guard; the peer relies on its own timeout.

Structure
REQ-036 Package bichannel_pkg: state enum, default parameter constants, cnt width.
REQ-037 Sub-module flit_fifo (parameters FLIT_W, DEPTH) implements storage and pointers; the FSM is in the top module.

Verification
REQ-038 After reset release, local_tx_req=1, peer idle -> REQ next cycle; peer_release at cycle 3 -> TURN for 2 cycles, then tx_en=1.
REQ-039 In REQ, peer_output_req and peer_release both rise the same cycle -> next state RX, output_req=0, tx_en never asserted.
REQ-040 local_tx_req held 20 cycles -> exactly 8 tx_en cycles, 2 DRAIN cycles, back to RX with inout_select=1.
REQ-041 rx_valid continuous, out_ready=0 -> 4 pushes, then rx_ready=0; out_ready=1 with rx_valid=1 at full -> pop only, push next cycle; data order preserved.
REQ-042 rst asserted in TX cycle 3 -> same-cycle output_req=0, tx_en=0, inout_select=1; FIFO empty.
